// File: rtl/approx_pkg.sv
// Shared types and elaboration-time helpers for the pipelined LOA adder.
// Stage and mask helpers take the adder geometry as arguments so any instance can reuse them.
package approx_pkg;

  typedef enum logic {
    MODE_EXACT = 1'b0,
    MODE_LOA   = 1'b1
  } mode_t;

  localparam int MAX_CHUNK       = 32;
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_CHUNK       = 4;
  localparam int DEF_APPROX_BITS = 4;
  localparam int STAGES          = DEF_WIDTH / DEF_CHUNK;

  function automatic int num_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Stage that receives the LOA carry (the one holding bit approx_bits);
  // equals the stage count when the carry lands in cout.
  function automatic int loa_carry_stage(input int approx_bits, input int chunk);
    return approx_bits / chunk;
  endfunction

  localparam int LOA_CARRY_STAGE = DEF_APPROX_BITS / DEF_CHUNK;

  // Bits of chunk 'stage' that fall below approx_bits are OR-approximated.
  function automatic logic [MAX_CHUNK-1:0] chunk_approx_mask(input int stage, input int chunk,
                                                             input int approx_bits);
    logic [MAX_CHUNK-1:0] m;
    m = {MAX_CHUNK{1'b0}};
    for (int i = 0; i < MAX_CHUNK; i++) begin
      if ((i < chunk) && ((stage * chunk + i) < approx_bits)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // The stage holding bit approx_bits-1 generates the LOA carry, which its
  // registered carry-out then delivers to loa_carry_stage().
  function automatic logic is_inject_stage(input int stage, input int chunk, input int approx_bits);
    if (approx_bits > 0) begin
      return logic'(((approx_bits - 1) / chunk) == stage);
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/loa_chunk_add.sv
// Combinational CHUNK-bit adder slice with per-bit OR approximation.
// Masked bits kill the ripple carry except the injecting bit, which emits a&b.
module loa_chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  input  logic [CHUNK-1:0] approx_mask_i,
  input  logic             loa_carry_inject_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o
);

  logic c_s;

  // Ripple through the chunk, switching each bit between OR and full-add.
  always_comb begin
    c_s = cin_i;
    s_o = {CHUNK{1'b0}};
    for (int i = 0; i < CHUNK; i++) begin
      if (approx_mask_i[i]) begin
        s_o[i] = a_i[i] | b_i[i];
        c_s    = loa_carry_inject_i & a_i[i] & b_i[i];
      end else begin
        s_o[i] = a_i[i] ^ b_i[i] ^ c_s;
        c_s    = (a_i[i] & b_i[i]) | (c_s & (a_i[i] ^ b_i[i]));
      end
    end
    co_o = c_s;
  end

endmodule

// File: rtl/loa_pipe_adder.sv
// Pipelined WIDTH-bit adder with per-beat selectable Lower-part-OR approximation.
// One CHUNK of the carry chain is resolved per stage; a global stall freezes every stage.
module loa_pipe_adder
  import approx_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CHUNK       = 4,
  parameter int APPROX_BITS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [CNT_W-1:0] op_count
);

  localparam int NS = num_stages(WIDTH, CHUNK);

  logic             advance_s;
  logic [NS-1:0]    vld_q;
  mode_t            mode_q  [NS];
  logic [NS-1:0]    c_q;
  logic [WIDTH-1:0] a_q     [NS];
  logic [WIDTH-1:0] b_q     [NS];
  logic [WIDTH-1:0] s_q     [NS];
  logic [WIDTH-1:0] merge_s [NS];
  logic [CHUNK-1:0] slice_s [NS];
  logic [NS-1:0]    slice_co;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;

  assign advance_s = !out_valid_q || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam logic [MAX_CHUNK-1:0] MASK_FULL = chunk_approx_mask(k, CHUNK, APPROX_BITS);
    localparam logic                 INJECT    = is_inject_stage(k, CHUNK, APPROX_BITS);
    logic             loa_s;
    logic [CHUNK-1:0] mask_s;

    assign loa_s  = (mode_q[k] == MODE_LOA);
    assign mask_s = loa_s ? MASK_FULL[CHUNK-1:0] : {CHUNK{1'b0}};

    loa_chunk_add #(.CHUNK(CHUNK)) u_add (
      .a_i               (a_q[k][k*CHUNK +: CHUNK]),
      .b_i               (b_q[k][k*CHUNK +: CHUNK]),
      .cin_i             (c_q[k]),
      .approx_mask_i     (mask_s),
      .loa_carry_inject_i(loa_s & INJECT),
      .s_o               (slice_s[k]),
      .co_o              (slice_co[k])
    );
  end

  // Splice each stage's freshly resolved chunk into its running partial sum.
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      merge_s[k]                   = s_q[k];
      merge_s[k][k*CHUNK +: CHUNK] = slice_s[k];
    end
  end

  // Stage valid/mode/carry, operand skew and partial-sum registers plus the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= {NS{1'b0}};
      c_q         <= {NS{1'b0}};
      for (int k = 0; k < NS; k++) begin
        mode_q[k] <= MODE_EXACT;
        a_q[k]    <= {WIDTH{1'b0}};
        b_q[k]    <= {WIDTH{1'b0}};
        s_q[k]    <= {WIDTH{1'b0}};
      end
      out_valid_q <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
    end else if (advance_s) begin
      vld_q[0]  <= in_valid;
      mode_q[0] <= approx_en ? MODE_LOA : MODE_EXACT;
      c_q[0]    <= cin;
      a_q[0]    <= a;
      b_q[0]    <= b;
      s_q[0]    <= {WIDTH{1'b0}};
      for (int k = 1; k < NS; k++) begin
        vld_q[k]  <= vld_q[k-1];
        mode_q[k] <= mode_q[k-1];
        c_q[k]    <= slice_co[k-1];
        a_q[k]    <= a_q[k-1];
        b_q[k]    <= b_q[k-1];
        s_q[k]    <= merge_s[k-1];
      end
      out_valid_q <= vld_q[NS-1];
      if (vld_q[NS-1]) begin
        sum_q  <= merge_s[NS-1];
        cout_q <= slice_co[NS-1];
      end else begin
        sum_q  <= sum_q;
        cout_q <= cout_q;
      end
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  // Saturating count of completed output handshakes.
  always_comb begin
    op_count_d = op_count_q;
    if (out_valid_q && out_ready && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      op_count_d = op_count_q;
    end
  end

  // Operation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= {CNT_W{1'b0}};
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_loa_pipe_adder.sv
// Directed self-checking bench for loa_pipe_adder (WIDTH=16, CHUNK=4, APPROX_BITS=4).
module tb_loa_pipe_adder;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [15:0] a         = 16'h0000;
  logic [15:0] b         = 16'h0000;
  logic        cin       = 1'b0;
  logic        approx_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic [15:0] op_count;

  int tests = 0;
  int fails = 0;

  logic [15:0] ea  [6];
  logic [15:0] eb  [6];
  logic        eci [6];
  logic        eap [6];
  logic [15:0] es  [6];
  logic        ec  [6];

  always #5 clk = ~clk;

  loa_pipe_adder #(.WIDTH(16), .CHUNK(4), .APPROX_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat into an idle pipe; result must appear exactly 4 edges after the handshake edge.
  task automatic run_single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic ci, input logic ap, input logic [15:0] exs, input logic exc);
    a = av; b = bv; cin = ci; approx_en = ap; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_lat%0d", tag, i), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(exs));
    chk({tag, "_cout"}, 32'(cout), 32'(exc));
    @(posedge clk); #1;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int nin;
    int nout;

    // Reset state
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_inrdy", 32'(in_ready), 32'd1);

    run_single("exact",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
    run_single("loa_nc", 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b0);
    run_single("loa_ci", 16'h0008, 16'h0008, 1'b1, 1'b1, 16'h0018, 1'b0);
    run_single("wrap1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_single("wrap2",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    chk("count5", 32'(op_count), 32'd5);

    // Back-to-back alternating modes with out_ready low in cycles 5-7
    ea  = '{16'h1234, 16'h0007, 16'h8000, 16'h0F0C, 16'hFFF0, 16'hFFF8};
    eb  = '{16'h1111, 16'h0009, 16'h8000, 16'h010A, 16'h0010, 16'h0008};
    eci = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    eap = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    es  = '{16'h2345, 16'h000F, 16'h0001, 16'h101E, 16'h0000, 16'h0008};
    ec  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    nin = 0;
    nout = 0;
    for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (nin < 6) begin
        in_valid = 1'b1; a = ea[nin]; b = eb[nin]; cin = eci[nin]; approx_en = eap[nin];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc <= 12) begin
        chk($sformatf("bp_inrdy_c%0d", cyc), 32'(in_ready), (cyc >= 5 && cyc <= 7) ? 32'd0 : 32'd1);
      end
      if (cyc >= 5 && cyc <= 7) begin
        chk($sformatf("bp_hold_c%0d", cyc), 32'({out_valid, sum}), 32'({1'b1, es[0]}));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_sum%0d", nout), 32'(sum), 32'(es[nout]));
        chk($sformatf("bp_cout%0d", nout), 32'(cout), 32'(ec[nout]));
        nout++;
      end
      if (in_valid && in_ready) nin++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_nout", 32'(nout), 32'd6);
    chk("bp_count", 32'(op_count), 32'd11);

    // Reset while the pipe is full and a result is waiting
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'h1000 + 16'(i); b = 16'h0001; cin = 1'b0; approx_en = 1'(i % 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_valid_pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid_rst", 32'(out_valid), 32'd0);
    chk("mid_count_rst", 32'(op_count), 32'd0);
    chk("mid_sum_rst", 32'(sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_quiet%0d", i), 32'(out_valid), 32'd0);
    end
    run_single("post_rst", 16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0);
    chk("post_count", 32'(op_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
